instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-low.
REQ-004 imem_req_o  output  1  instruction-memory request.
REQ-005 imem_addr_o  output  32  word address of the request.
REQ-006 imem_ack_i  input  1  memory response valid, for one cycle per request.
REQ-007 imem_data_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-008 stall_i  input  1  downstream decode stage not ready to consume.
REQ-009 redirect_i  input  1  branch/jump taken; discard current fetch.
REQ-010 redirect_pc_i  input  32  redirect target, sampled when redirect_i=1.
REQ-011 instr_valid_o  output  1  instr_o/pc_o hold a consumable instruction.
REQ-012 instr_o  output  32  fetched instruction word.
REQ-013 pc_o  output  32  address of instr_o.
REQ-014 pc_plus4_o  output  32  pc_o+4, modulo 2^32, combinational.
REQ-015 imm16_o  output  16  instr_o[15:0], combinational; the input to the sign-extend stage.

Function
REQ-016 States: FETCH (request outstanding), HOLD (instruction presented), FLUSH (outstanding request whose response is discarded).
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc; request and address stay stable until imem_ack_i=1.
REQ-018 FETCH, ack=1, no redirect: instr_o<=imem_data_i, instr_valid_o<=1, go HOLD.
REQ-019 HOLD, stall_i=1, no redirect: all outputs held unchanged, imem_req_o=0.
REQ-020 HOLD, stall_i=0, no redirect: instruction consumed at this edge; pc<=pc+4, instr_valid_o<=0, go FETCH.
REQ-021 Zero-wait memory throughput is one instruction per two cycles; ack-to-instr_valid_o latency is one cycle.
REQ-022 redirect_i has priority over stall_i in every state.
REQ-023 HOLD with redirect: instr_valid_o<=0, pc<=redirect_pc_i, go FETCH.
REQ-024 FETCH with redirect and ack in the same cycle: response discarded, pc<=redirect_pc_i, stay FETCH.
REQ-025 FETCH with redirect and no ack: target latched, go FLUSH; the outstanding request is never withdrawn.
REQ-026 FLUSH: imem_req_o=1 with the old address until ack; the response is discarded, pc<=latched target, go FETCH.
REQ-027 Redirect in FLUSH overwrites the latched target (last redirect wins); redirect with ack in FLUSH uses the new target.
REQ-028 redirect_pc_i[1:0] is ignored; pc[1:0] is always 2'b00.
REQ-029 pc increment wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-030 instr_valid_o is never 1 in FETCH or FLUSH.

Reset
REQ-031 While rst_i=0 at a rising edge: pc<=RESET_PC, state<=FETCH, instr_o<=0, instr_valid_o<=0, latched target<=0.
REQ-032 imem_req_o=0 in any cycle where rst_i=0.
REQ-033 Reset asserted mid-request abandons it; an ack arriving in the first cycle after reset release is ignored unless a request was issued in that cycle.

Structure
REQ-034 Shared package holds the state encoding (FETCH/HOLD/FLUSH), INSTR_WIDTH=32, IMM_WIDTH=16 and the RESET_PC default.
REQ-035 One sub-module, fetch_pc_reg: 32-bit PC register with load, increment-by-4 and synchronous active-low reset.

Verification
REQ-036 Reset, zero-wait memory returning 32'h2002_0005 at addr 0 -> req at 0; valid next cycle with pc_o=0, imm16_o=16'h0005, pc_plus4_o=4; next fetch at 4.
REQ-037 stall_i=1 for 3 cycles in HOLD -> instr_o, pc_o and valid unchanged, imem_req_o=0; on release, next request at pc+4.
REQ-038 Redirect to 32'h0000_0103 while ack is delayed 2 cycles -> FLUSH; old response dropped; next request at 32'h0000_0100; no valid pulse for the dropped word.
REQ-039 pc=32'hFFFF_FFFC consumed -> next imem_addr_o=32'h0000_0000.
REQ-040 Redirect and stall_i=1 together in HOLD -> valid drops, next request at the redirect target.
REQ-041 rst_i=0 asserted while a request is outstanding -> imem_req_o=0 in that cycle; first request after release at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned IMM_WIDTH   = 16;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits never reach the PC.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment-by-4.
module fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(4);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, holds the fetched
// word until decode consumes it, and drains redirected requests via FLUSH.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
  output logic [IMM_WIDTH-1:0]   imm16_o
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_load_c;
  logic                  pc_inc_c;
  logic [ADDR_WIDTH-1:0] pc_next_c;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .load    (pc_load_c),
    .inc     (pc_inc_c),
    .load_pc (pc_next_c),
    .pc      (pc)
  );

  // PC update: redirects load the target, consumption in HOLD advances by 4.
  always_comb begin
    pc_load_c = 1'b0;
    pc_inc_c  = 1'b0;
    pc_next_c = word_align(redirect_pc_i);
    case (state)
      ST_FETCH: pc_load_c = redirect_i && imem_ack_i;
      ST_HOLD: begin
        if (redirect_i) pc_load_c = 1'b1;
        else            pc_inc_c  = !stall_i;
      end
      ST_FLUSH: begin
        if (imem_ack_i) begin
          pc_load_c = 1'b1;
          if (!redirect_i) pc_next_c = target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= ST_FETCH;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      target        <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect_i) begin
            // Without an ack the request is still in flight and must be drained.
            if (!imem_ack_i) begin
              target <= word_align(redirect_pc_i);
              state  <= ST_FLUSH;
            end
          end else if (imem_ack_i) begin
            instr_o       <= imem_data_i;
            instr_valid_o <= 1'b1;
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_i || !stall_i) begin
            instr_valid_o <= 1'b0;
            state         <= ST_FETCH;
          end
        end
        ST_FLUSH: begin
          if (imem_ack_i) begin
            state <= ST_FETCH;
          end else if (redirect_i) begin
            target <= word_align(redirect_pc_i);
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Request is gated by reset so an in-flight fetch is abandoned immediately.
  assign imem_req_o  = rst_i && (state != ST_HOLD);
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + ADDR_WIDTH'(4);
  assign imm16_o     = instr_o[IMM_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a hand-driven memory port.
module tb_instr_fetch;

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [15:0] imm16_o;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .imm16_o       (imm16_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // Reset state
    step(); step();
    check("rst_req",   32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_pc",    pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);

    // Zero-wait fetch at 0
    rst_i = 1'b1; #1;
    check("f0_req",  32'(imem_req_o), 32'd1);
    check("f0_addr", imem_addr_o, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'h2002_0005;
    step();
    imem_ack_i = 1'b0;
    check("f0_valid", 32'(instr_valid_o), 32'd1);
    check("f0_instr", instr_o, 32'h2002_0005);
    check("f0_pc",    pc_o, 32'h0);
    check("f0_imm",   32'(imm16_o), 32'h0005);
    check("f0_pc4",   pc_plus4_o, 32'h4);
    check("f0_holdreq", 32'(imem_req_o), 32'd0);
    step();
    check("f1_req",   32'(imem_req_o), 32'd1);
    check("f1_addr",  imem_addr_o, 32'h4);
    check("f1_valid", 32'(instr_valid_o), 32'd0);

    // Stall for three cycles in HOLD
    imem_ack_i = 1'b1; imem_data_i = 32'h1111_0004;
    step();
    imem_ack_i = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_instr", instr_o, 32'h1111_0004);
      check("stall_pc",    pc_o, 32'h4);
      check("stall_req",   32'(imem_req_o), 32'd0);
    end
    stall_i = 1'b0;
    step();
    check("unstall_req",  32'(imem_req_o), 32'd1);
    check("unstall_addr", imem_addr_o, 32'h8);

    // Redirect with delayed ack drains through FLUSH
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    check("fl_req",   32'(imem_req_o), 32'd1);
    check("fl_addr",  imem_addr_o, 32'h8);
    check("fl_valid", 32'(instr_valid_o), 32'd0);
    step();
    check("fl_addr2", imem_addr_o, 32'h8);
    imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 1'b0;
    check("fl_drop_valid", 32'(instr_valid_o), 32'd0);
    check("fl_new_addr",   imem_addr_o, 32'h0000_0100);
    check("fl_new_req",    32'(imem_req_o), 32'd1);

    // Redirect and ack together in FETCH
    imem_ack_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step();
    imem_ack_i = 1'b0; redirect_i = 1'b0;
    check("ra_valid", 32'(instr_valid_o), 32'd0);
    check("ra_addr",  imem_addr_o, 32'h0000_0200);

    // Last redirect in FLUSH wins, including one coincident with the ack
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    step();
    redirect_pc_i = 32'h0000_0400;
    step();
    check("lw_old_addr", imem_addr_o, 32'h0000_0200);
    imem_ack_i = 1'b1; redirect_pc_i = 32'h0000_0502;
    step();
    imem_ack_i = 1'b0; redirect_i = 1'b0;
    check("lw_addr",  imem_addr_o, 32'h0000_0500);
    check("lw_valid", 32'(instr_valid_o), 32'd0);

    // PC wrap at the top of the address space
    imem_ack_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0; imem_data_i = 32'hCAFE_F00D;
    check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    step();
    imem_ack_i = 1'b0;
    check("wr_valid", 32'(instr_valid_o), 32'd1);
    check("wr_pc",    pc_o, 32'hFFFF_FFFC);
    check("wr_pc4",   pc_plus4_o, 32'h0);
    check("wr_imm",   32'(imm16_o), 32'h0000_F00D);
    step();
    check("wr_next_addr", imem_addr_o, 32'h0);

    // Redirect beats stall in HOLD
    imem_ack_i = 1'b1; imem_data_i = 32'h0BAD_0001;
    step();
    imem_ack_i = 1'b0;
    check("rs_valid_pre", 32'(instr_valid_o), 32'd1);
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    check("rs_valid", 32'(instr_valid_o), 32'd0);
    check("rs_req",   32'(imem_req_o), 32'd1);
    check("rs_addr",  imem_addr_o, 32'h0000_0040);

    // Reset while a request is outstanding
    rst_i = 1'b0; #1;
    check("mr_req", 32'(imem_req_o), 32'd0);
    imem_ack_i = 1'b1; imem_data_i = 32'h7777_7777;
    step();
    imem_ack_i = 1'b0;
    check("mr_valid", 32'(instr_valid_o), 32'd0);
    check("mr_pc",    pc_o, 32'h0);
    rst_i = 1'b1; #1;
    check("mr_rel_req",  32'(imem_req_o), 32'd1);
    check("mr_rel_addr", imem_addr_o, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'h2002_0005;
    step();
    imem_ack_i = 1'b0;
    check("mr_fetch_valid", 32'(instr_valid_o), 32'd1);
    check("mr_fetch_instr", instr_o, 32'h2002_0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
